// File: rtl/division.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient
// bit per clock, driven by a start/done handshake.
module division #(
    parameter int DW = 3,
    parameter int VW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] D,
    input  logic [VW-1:0] V,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          Z
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [DW-1:0] d_lat;
    logic [VW-1:0] v_lat;
    logic [VW:0]   p;
    logic [DW-1:0] quo;
    logic [CW-1:0] cnt;

    logic [VW:0]   p_sh;
    logic [VW:0]   p_nx;
    logic          ge;
    logic [DW-1:0] q_nx;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        p_sh      = {p[VW-1:0], d_lat[cnt]};
        ge        = (p_sh >= {1'b0, v_lat});
        p_nx      = ge ? (p_sh - {1'b0, v_lat}) : p_sh;
        q_nx      = quo;
        q_nx[cnt] = ge;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            d_lat <= '0;
            v_lat <= '0;
            p     <= '0;
            quo   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            Z     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        d_lat <= D;
                        v_lat <= V;
                        p     <= '0;
                        quo   <= '0;
                        cnt   <= CW'(DW - 1);
                        if (V == '0) begin
                            // Divide by zero short-circuits straight to a result.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            Q     <= '1;
                            R     <= '0;
                            Z     <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    p   <= p_nx;
                    quo <= q_nx;
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Q     <= q_nx;
                        R     <= p_nx[VW-1:0];
                        Z     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_division.sv
// Scoreboard bench for division: stimulus pushes expected results, a negedge
// monitor pops and compares on every done pulse.
module tb_division;
    localparam int DW = 3;
    localparam int VW = 2;
    localparam int PER = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] D;
    logic [VW-1:0] V;
    logic          busy;
    logic          done;
    logic [DW-1:0] Q;
    logic [VW-1:0] R;
    logic          Z;

    division #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .D(D), .V(V),
        .busy(busy), .done(done), .Q(Q), .R(R), .Z(Z)
    );

    always #(PER/2) clk = ~clk;

    typedef struct {
        int q;
        int r;
        int z;
        int t;
        int nbusy;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int last_q = 0, last_r = 0, last_z = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer division, all-ones quotient on divide by zero.
    function automatic exp_t model(input int d, input int v, input int t_acc);
        exp_t e;
        if (v == 0) begin
            e.q = (1 << DW) - 1; e.r = 0; e.z = 1;
            e.t = t_acc + PER/2; e.nbusy = 0;
        end else begin
            e.q = d / v; e.r = d % v; e.z = 0;
            e.t = t_acc + DW*PER + PER/2; e.nbusy = DW;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            busy_cnt = 0;
            last_q = 0; last_r = 0; last_z = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                chk("hold_q", int'(Q), last_q);
                chk("hold_r", int'(R), last_r);
                chk("hold_z", int'(Z), last_z);
            end
            if (done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("q", int'(Q), e.q);
                    chk("r", int'(R), e.r);
                    chk("z", int'(Z), e.z);
                    chk("done_time", int'($time), e.t);
                    chk("busy_cycles", busy_cnt, e.nbusy);
                    last_q = e.q; last_r = e.r; last_z = e.z;
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic do_op(input int d, input int v, input bit hold);
        start = 1'b1;
        D = DW'(d);
        V = VW'(v);
        @(posedge clk);
        sb.push_back(model(d, v, int'($time)));
        if (v != 0) repeat (DW) @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int dc0;
        rst = 1'b1; start = 1'b0; D = '0; V = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", int'(Q), 0);
        chk("rst_r", int'(R), 0);
        chk("rst_z", int'(Z), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_op(6, 3, 0); @(negedge clk);
        do_op(7, 2, 0); @(negedge clk);
        do_op(5, 3, 0); @(negedge clk);
        do_op(7, 1, 0); @(negedge clk);
        do_op(0, 3, 0); @(negedge clk);
        do_op(4, 0, 0); @(negedge clk);
        do_op(4, 2, 0); @(negedge clk);
        drain();

        // Exhaustive back-to-back sweep.
        dc0 = done_cnt;
        for (int d = 0; d < (1 << DW); d++)
            for (int v = 0; v < (1 << VW); v++)
                do_op(d, v, 1);
        start = 1'b0;
        drain();
        chk("sweep_dones", done_cnt - dc0, 32);
        @(negedge clk);

        // Start during CALC is ignored; inputs may change freely.
        start = 1'b1; D = 3'd6; V = 2'd2;
        @(posedge clk);
        sb.push_back(model(6, 2, int'($time)));
        @(negedge clk);
        start = 1'b1; D = 3'd1; V = 2'd1;
        @(negedge clk);
        start = 1'b0; D = DW'($urandom); V = VW'($urandom);
        repeat (2) @(negedge clk);
        drain();
        @(negedge clk);

        // Asynchronous reset in the second CALC cycle aborts the operation.
        dc0 = done_cnt;
        start = 1'b1; D = 3'd7; V = 2'd3;
        @(posedge clk);
        sb.push_back(model(7, 3, int'($time)));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_q", int'(Q), 0);
        chk("abort_r", int'(R), 0);
        chk("abort_z", int'(Z), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_flush", sb.size(), 0);
        do_op(7, 3, 0); @(negedge clk);
        drain();

        // Randomized mix of isolated and back-to-back operations.
        for (int i = 0; i < 60; i++) begin
            bit hold;
            hold = ($urandom_range(0, 1) == 1);
            do_op(int'($urandom_range(0, (1 << DW) - 1)),
                  int'($urandom_range(0, (1 << VW) - 1)), hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(PER * 20000);
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end
endmodule
